// File: rtl/awgn_pkg.sv
// Shared constants, FSM encoding and accumulator width helpers for the AWGN
// statistics monitor.
package awgn_pkg;

  localparam int SAMPLE_W   = 16;   // Q5.11 sample width
  localparam int FRAC_W     = 11;   // Q5.11 fraction bits
  localparam int THRESH_DEF = 8192; // 4.0 sigma in Q5.11

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Sum of 2^(log2_win+1) signed 16-bit samples.
  function automatic int sum_w(input int log2_win);
    return SAMPLE_W + 1 + log2_win;
  endfunction

  // Sum of 2^(log2_win+1) squares, each below 2^31.
  function automatic int sumsq_w(input int log2_win);
    return 2 * SAMPLE_W + log2_win;
  endfunction

endpackage

// File: rtl/awgn_sq_abs.sv
// Pipeline stage S2 for one sample: square, magnitude and outlier flag,
// all registered.
module awgn_sq_abs
  import awgn_pkg::*;
#(
  parameter int THRESH = THRESH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] i_x,
  output logic [2*SAMPLE_W-2:0]      o_sq,
  output logic [SAMPLE_W-1:0]        o_abs,
  output logic                       o_outlier
);

  localparam logic [SAMPLE_W-1:0] THR = SAMPLE_W'(THRESH);

  logic [SAMPLE_W-1:0]   w_abs;
  logic [2*SAMPLE_W-2:0] w_abs_ext;

  // Unsigned magnitude: -32768 maps to 32768 without overflow.
  assign w_abs     = i_x[SAMPLE_W-1] ? (~i_x + 1'b1) : i_x;
  assign w_abs_ext = {{(SAMPLE_W-1){1'b0}}, w_abs};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_sq      <= '0;
      o_abs     <= '0;
      o_outlier <= 1'b0;
    end else begin
      o_sq      <= w_abs_ext * w_abs_ext;
      o_abs     <= w_abs;
      o_outlier <= (w_abs > THR);
    end
  end

endmodule

// File: rtl/awgn_stat_monitor.sv
// Windowed mean / mean-square / outlier / peak monitor for the Box-Muller
// AWGN sample pair. Three-stage datapath behind an IDLE/ACCUM/DRAIN/DONE FSM.
module awgn_stat_monitor
  import awgn_pkg::*;
#(
  parameter int LOG2_WIN = 10,
  parameter int THRESH   = THRESH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] x0,
  input  logic signed [SAMPLE_W-1:0] x1,
  input  logic                       ack,
  output logic                       busy,
  output logic                       done,
  output logic signed [SAMPLE_W-1:0] mean_out,
  output logic [31:0]                msq_out,
  output logic [LOG2_WIN+1:0]        outlier_cnt,
  output logic [SAMPLE_W-1:0]        peak_abs
);

  localparam int SUM_W = sum_w(LOG2_WIN);
  localparam int SQ_W  = sumsq_w(LOG2_WIN);
  localparam int CNT_W = LOG2_WIN + 2;
  localparam int SHIFT = LOG2_WIN + 1;

  state_t                     r_state;
  logic [LOG2_WIN-1:0]        r_pair_cnt;
  logic                       r_full;
  logic                       r_drain;
  logic                       r_s1_vld, r_s1_last, r_s2_vld;
  logic signed [SAMPLE_W-1:0] r_s1_x0, r_s1_x1, r_s2_x0, r_s2_x1;
  logic [2*SAMPLE_W-2:0]      w_sq0, w_sq1;
  logic [SAMPLE_W-1:0]        w_abs0, w_abs1, w_abs_max, w_peak_next;
  logic                       w_out0, w_out1;
  logic                       w_accept, w_start_win;
  logic signed [SUM_W-1:0]    r_sum;
  logic [SQ_W-1:0]            r_sumsq;
  logic [CNT_W-1:0]           r_out_cnt;
  logic [SAMPLE_W-1:0]        r_peak;

  assign w_accept    = (r_state == ST_ACCUM) && sample_valid && !r_full;
  assign w_start_win = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pair_cnt <= '0;
      r_full     <= 1'b0;
      r_drain    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_state    <= ST_ACCUM;
          r_pair_cnt <= '0;
          r_full     <= 1'b0;
          r_drain    <= 1'b0;
          busy       <= 1'b1;
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_pair_cnt <= r_pair_cnt + 1'b1;
            if (&r_pair_cnt) r_full <= 1'b1;
          end
          // Leave once the final pair sits in S1; DRAIN then covers S2 and S3.
          if (r_s1_last) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) begin
            r_state <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        ST_DONE: if (ack) begin
          r_state <= ST_IDLE;
          done    <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_x0   <= '0;
      r_s1_x1   <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_x0   <= '0;
      r_s2_x1   <= '0;
    end else begin
      r_s1_vld  <= w_accept;
      r_s1_last <= w_accept && (&r_pair_cnt);
      if (w_accept) begin
        r_s1_x0 <= x0;
        r_s1_x1 <= x1;
      end
      r_s2_vld <= r_s1_vld;
      r_s2_x0  <= r_s1_x0;
      r_s2_x1  <= r_s1_x1;
    end
  end

  awgn_sq_abs #(.THRESH(THRESH)) u_sq_abs0 (
    .clk(clk), .reset(reset), .i_x(r_s1_x0),
    .o_sq(w_sq0), .o_abs(w_abs0), .o_outlier(w_out0)
  );

  awgn_sq_abs #(.THRESH(THRESH)) u_sq_abs1 (
    .clk(clk), .reset(reset), .i_x(r_s1_x1),
    .o_sq(w_sq1), .o_abs(w_abs1), .o_outlier(w_out1)
  );

  assign w_abs_max   = (w_abs0 > w_abs1) ? w_abs0 : w_abs1;
  assign w_peak_next = (w_abs_max > r_peak) ? w_abs_max : r_peak;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum       <= '0;
      r_sumsq     <= '0;
      r_out_cnt   <= '0;
      r_peak      <= '0;
      mean_out    <= '0;
      msq_out     <= '0;
      outlier_cnt <= '0;
      peak_abs    <= '0;
    end else begin
      if (w_start_win) begin
        r_sum     <= '0;
        r_sumsq   <= '0;
        r_out_cnt <= '0;
        r_peak    <= '0;
      end else if (r_s2_vld) begin
        r_sum     <= r_sum
                     + {{(SUM_W-SAMPLE_W){r_s2_x0[SAMPLE_W-1]}}, r_s2_x0}
                     + {{(SUM_W-SAMPLE_W){r_s2_x1[SAMPLE_W-1]}}, r_s2_x1};
        r_sumsq   <= r_sumsq + SQ_W'(w_sq0) + SQ_W'(w_sq1);
        r_out_cnt <= r_out_cnt + CNT_W'(w_out0) + CNT_W'(w_out1);
        r_peak    <= w_peak_next;
      end
      // Slicing the top bits is a floor shift by the sample count.
      if ((r_state == ST_DRAIN) && r_drain) begin
        mean_out    <= r_sum[SHIFT +: SAMPLE_W];
        msq_out     <= {1'b0, r_sumsq[SHIFT +: 2*SAMPLE_W-1]};
        outlier_cnt <= r_out_cnt;
        peak_abs    <= r_peak;
      end
    end
  end

endmodule

// File: tb/tb_awgn_stat_monitor.sv
// Self-checking bench for awgn_stat_monitor: fixed vector table, random windows
// against a plain-arithmetic statistics model, and FSM corner sequences.
module tb_awgn_stat_monitor;

  localparam int LOG2_WIN = 2;
  localparam int THRESH   = 8192;
  localparam int NP       = 2 ** LOG2_WIN;

  logic               clk = 1'b0;
  logic               reset, start, sample_valid, ack;
  logic signed [15:0] x0, x1;
  logic               busy, done;
  logic signed [15:0] mean_out;
  logic [31:0]        msq_out;
  logic [LOG2_WIN+1:0] outlier_cnt;
  logic [15:0]        peak_abs;

  int n_checks = 0;
  int n_errors = 0;

  logic signed [15:0] q[$];
  logic signed [15:0] win_x0[NP];
  logic signed [15:0] win_x1[NP];
  longint             prev_mean, prev_msq, prev_oc, prev_pk;
  bit                 have_prev = 1'b0;

  typedef struct {
    logic signed [15:0] x0;
    logic signed [15:0] x1;
    bit                 gapped;
    longint             mean;
    longint             msq;
    longint             oc;
    longint             pk;
  } vec_t;

  vec_t vecs[4];

  awgn_stat_monitor #(.LOG2_WIN(LOG2_WIN), .THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .x0(x0), .x1(x1), .ack(ack), .busy(busy), .done(done),
    .mean_out(mean_out), .msq_out(msq_out), .outlier_cnt(outlier_cnt),
    .peak_abs(peak_abs)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic logic signed [15:0] rand_sample();
    logic [15:0] r;
    if ($urandom_range(0, 3) == 0) r = 16'($urandom);
    else r = 16'($urandom_range(0, 8191)) - 16'd4096;
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NP; i++) begin
      win_x0[i] = rand_sample();
      win_x1[i] = rand_sample();
    end
  endtask

  task automatic check_held(input string tag);
    if (have_prev) begin
      check({tag, "_mean"}, mean_out, prev_mean);
      check({tag, "_msq"}, msq_out, prev_msq);
      check({tag, "_oc"}, outlier_cnt, prev_oc);
      check({tag, "_pk"}, peak_abs, prev_pk);
    end
  endtask

  // Statistics of every accepted sample, straight from the definitions.
  task automatic check_model();
    longint s, sq, oc, pk, v, a;
    s = 0; sq = 0; oc = 0; pk = 0;
    foreach (q[i]) begin
      v  = q[i];
      s  += v;
      sq += v * v;
      a  = (v < 0) ? -v : v;
      if (a > THRESH) oc++;
      if (a > pk) pk = a;
    end
    prev_mean = s >>> (LOG2_WIN + 1);
    prev_msq  = sq >> (LOG2_WIN + 1);
    prev_oc   = oc;
    prev_pk   = pk;
    have_prev = 1'b1;
    check_held("model");
  endtask

  task automatic run_window(input bit gapped, input bit poke);
    int acc, guard, lat;
    q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_accum", busy, 1);
    check("done_accum", done, 0);
    check_held("accum_hold");
    acc = 0;
    guard = 0;
    while (acc < NP && guard < 100) begin
      guard++;
      sample_valid = gapped ? (guard % 2 == 1) : 1'b1;
      start = poke && (acc == 1);
      if (sample_valid) begin
        x0 = win_x0[acc];
        x1 = win_x1[acc];
        q.push_back(x0);
        q.push_back(x1);
        acc++;
      end else begin
        x0 = 16'sh7fff;
        x1 = 16'sh7fff;
      end
      tick();
    end
    sample_valid = 1'b0;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      start = poke && (lat == 1);
      tick();
      lat++;
    end
    start = 1'b0;
    check("done_latency", lat, 3);
    check("busy_done_excl", busy, 0);
    check_model();
    sample_valid = 1'b1;
    x0 = 16'sh7fff;
    x1 = -16'sh7fff;
    tick();
    tick();
    sample_valid = 1'b0;
    check("done_hold", done, 1);
    check_held("done_hold");
  endtask

  task automatic finish_ack(input bit with_start);
    ack = 1'b1;
    start = with_start;
    tick();
    ack = 1'b0;
    start = 1'b0;
    check("ack_done", done, 0);
    check("ack_busy", busy, 0);
    if (with_start) begin
      tick();
      tick();
      check("ack_start_ignored", busy, 0);
    end
  endtask

  initial begin
    vecs[0] = '{16'sd2048,   16'sd2048,  1'b0, 2048,   4194304,   0, 2048};
    vecs[1] = '{16'sd2048,  -16'sd2048,  1'b1, 0,      4194304,   0, 2048};
    vecs[2] = '{-16'sd32768, 16'sd8193,  1'b0, -12288, 570433536, 8, 32768};
    vecs[3] = '{-16'sd32768, 16'sd8192,  1'b1, -12288, 570425344, 4, 32768};

    reset = 1'b0; start = 1'b0; sample_valid = 1'b0; ack = 1'b0;
    x0 = '0; x1 = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mean", mean_out, 0);
    check("rst_msq", msq_out, 0);
    check("rst_oc", outlier_cnt, 0);
    check("rst_pk", peak_abs, 0);
    @(negedge clk) reset = 1'b1;
    tick();

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NP; i++) begin
        win_x0[i] = vecs[k].x0;
        win_x1[i] = vecs[k].x1;
      end
      run_window(vecs[k].gapped, 1'b0);
      check("tbl_mean", mean_out, vecs[k].mean);
      check("tbl_msq", msq_out, vecs[k].msq);
      check("tbl_oc", outlier_cnt, vecs[k].oc);
      check("tbl_pk", peak_abs, vecs[k].pk);
      finish_ack(1'b0);
    end

    // start pulsed in ACCUM/DRAIN, then ack+start together in DONE
    fill_random();
    run_window(1'b0, 1'b1);
    finish_ack(1'b1);
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      x0 = rand_sample();
      x1 = rand_sample();
      tick();
    end
    sample_valid = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check_held("idle_hold");

    for (int w = 0; w < 6; w++) begin
      fill_random();
      run_window(bit'($urandom_range(0, 1)), 1'b0);
      finish_ack(1'b0);
    end

    // asynchronous reset in the middle of a window
    fill_random();
    start = 1'b1;
    tick();
    start = 1'b0;
    sample_valid = 1'b1;
    x0 = 16'sd1000;
    x1 = -16'sd3000;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_mean", mean_out, 0);
    check("mid_rst_msq", msq_out, 0);
    check("mid_rst_oc", outlier_cnt, 0);
    check("mid_rst_pk", peak_abs, 0);
    @(negedge clk);
    sample_valid = 1'b0;
    reset = 1'b1;
    tick();
    prev_mean = 0; prev_msq = 0; prev_oc = 0; prev_pk = 0;
    have_prev = 1'b1;
    fill_random();
    run_window(1'b1, 1'b0);
    finish_ack(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
